// File: rtl/krypton_pkg.sv
`default_nettype none
// ============================================================================
// Module      : krypton_pkg
// Description : Shared parameters for the Krypton command front end.
// Revision    : 1.0 - initial release
// ============================================================================
package krypton_pkg;

  // Width of command buffer addresses seen by the command processor.
  localparam int ADDR_WIDTH = 32;

endpackage
`default_nettype wire

// File: rtl/krypton_cmd_queue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : krypton_cmd_queue_scheduler
// Description : Per-queue submission FIFOs, priority-aware round-robin
//               arbiter, single-in-flight launch FSM towards the command
//               processor, per-queue retirement counters and a hang watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module krypton_cmd_queue_scheduler
  import krypton_pkg::*;
#(
  parameter int NUM_QUEUES = 4,
  parameter int QDEPTH     = 4,
  parameter int QID_W      = $clog2(NUM_QUEUES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_QUEUES-1:0]            sub_valid,
  output logic [NUM_QUEUES-1:0]            sub_ready,
  input  logic [NUM_QUEUES*ADDR_WIDTH-1:0] sub_base,
  input  logic [NUM_QUEUES*32-1:0]         sub_size,
  input  logic [NUM_QUEUES-1:0]            q_enable,
  input  logic [NUM_QUEUES-1:0]            q_high_prio,
  output logic [ADDR_WIDTH-1:0]            cp_base,
  output logic [31:0]                      cp_size,
  output logic                             cp_start,
  input  logic                             cp_busy,
  input  logic                             cp_done,
  output logic                             done_pulse,
  output logic [QID_W-1:0]                 done_qid,
  output logic [NUM_QUEUES*16-1:0]         retired_count,
  input  logic [31:0]                      timeout_cycles,
  output logic                             hang_flag,
  input  logic                             hang_clear,
  output logic                             sched_idle
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_RETIRE = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [QID_W-1:0]       grant_q, grant_d;
  logic [QID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]  cp_base_q, cp_base_d;
  logic [31:0]            cp_size_q, cp_size_d;
  logic                   cp_start_q, cp_start_d;
  logic                   done_pulse_q, done_pulse_d;
  logic [QID_W-1:0]       done_qid_q, done_qid_d;
  logic [31:0]            wd_cnt_q, wd_cnt_d;
  logic                   hang_q, hang_d;
  logic [15:0]            ret_cnt_q [NUM_QUEUES];
  logic [15:0]            ret_cnt_d [NUM_QUEUES];

  logic [NUM_QUEUES-1:0]  push, pop, full, empty;
  logic [ADDR_WIDTH-1:0]  head_base [NUM_QUEUES];
  logic [31:0]            head_size [NUM_QUEUES];

  logic [NUM_QUEUES-1:0]  eligible, hi_eligible, candidates;
  logic [QID_W-1:0]       pick;
  logic [31:0]            wd_inc;
  logic                   wd_expire;

  // First set bit of req at or above start, wrapping past the top queue.
  function automatic logic [QID_W-1:0] rr_pick(input logic [NUM_QUEUES-1:0] req,
                                               input logic [QID_W-1:0]      start);
    logic [QID_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = QID_W'(idx);
      end
    end
    return sel;
  endfunction

  // Slots are judged from registered occupancy only, so a same-cycle pop
  // never lets an extra push in.
  assign sub_ready = ~full;
  assign push      = sub_valid & ~full;

  for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_fifo
    logic [ADDR_WIDTH-1:0] base_mem [QDEPTH];
    logic [31:0]           size_mem [QDEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign pop[gi]       = (state_q == S_LAUNCH) && (grant_q == QID_W'(gi));
    assign full[gi]      = (cnt_q == CNT_W'(QDEPTH));
    assign empty[gi]     = (cnt_q == '0);
    assign head_base[gi] = base_mem[rd_ptr_q];
    assign head_size[gi] = size_mem[rd_ptr_q];

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push[gi]);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop[gi]);
      cnt_d    = cnt_q + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
    end

    // FIFO control registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    // Entry storage; contents are meaningless while the slot is unoccupied.
    always_ff @(posedge clk) begin
      if (push[gi]) begin
        base_mem[wr_ptr_q] <= sub_base[gi*ADDR_WIDTH +: ADDR_WIDTH];
        size_mem[wr_ptr_q] <= sub_size[gi*32 +: 32];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_ret_out
    assign retired_count[gi*16 +: 16] = ret_cnt_q[gi];
  end

  // Priority class filter followed by round-robin selection.
  always_comb begin
    eligible    = q_enable & ~empty;
    hi_eligible = eligible & q_high_prio;
    candidates  = (|hi_eligible) ? hi_eligible : eligible;
    pick        = rr_pick(candidates, rr_ptr_q);
  end

  // Scheduler next-state, watchdog and retirement bookkeeping.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    cp_base_d    = cp_base_q;
    cp_size_d    = cp_size_q;
    cp_start_d   = 1'b0;
    done_pulse_d = 1'b0;
    done_qid_d   = done_qid_q;
    wd_cnt_d     = wd_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    wd_inc       = wd_cnt_q + 32'd1;
    wd_expire    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          grant_d = pick;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cp_base_d = head_base[grant_q];
        cp_size_d = head_size[grant_q];
        // Empty command buffers retire without touching the processor.
        state_d   = (head_size[grant_q] == 32'd0) ? S_RETIRE : S_START;
      end
      S_START: begin
        if (!cp_busy) begin
          cp_start_d = 1'b1;
          wd_cnt_d   = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        wd_cnt_d  = wd_inc;
        wd_expire = (timeout_cycles != 32'd0) && (wd_inc == timeout_cycles);
        if (cp_done) state_d = S_RETIRE;
      end
      S_RETIRE: begin
        done_pulse_d       = 1'b1;
        done_qid_d         = grant_q;
        ret_cnt_d[grant_q] = ret_cnt_q[grant_q] + 16'd1;
        rr_ptr_d           = (grant_q == QID_W'(NUM_QUEUES-1)) ? '0 : grant_q + QID_W'(1);
        state_d            = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh expiry beats a simultaneous clear.
    hang_d = wd_expire ? 1'b1 : (hang_clear ? 1'b0 : hang_q);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      cp_base_q    <= '0;
      cp_size_q    <= '0;
      cp_start_q   <= 1'b0;
      done_pulse_q <= 1'b0;
      done_qid_q   <= '0;
      wd_cnt_q     <= '0;
      hang_q       <= 1'b0;
      for (int i = 0; i < NUM_QUEUES; i++) ret_cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      cp_base_q    <= cp_base_d;
      cp_size_q    <= cp_size_d;
      cp_start_q   <= cp_start_d;
      done_pulse_q <= done_pulse_d;
      done_qid_q   <= done_qid_d;
      wd_cnt_q     <= wd_cnt_d;
      hang_q       <= hang_d;
      ret_cnt_q    <= ret_cnt_d;
    end
  end

  assign cp_base    = cp_base_q;
  assign cp_size    = cp_size_q;
  assign cp_start   = cp_start_q;
  assign done_pulse = done_pulse_q;
  assign done_qid   = done_qid_q;
  assign hang_flag  = hang_q;
  assign sched_idle = (state_q == S_IDLE) && (&empty);

endmodule
`default_nettype wire

// File: tb/tb_krypton_cmd_queue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_krypton_cmd_queue_scheduler
// Description : Self-checking bench with a transaction-level model of the
//               queue scheduler and a simple command processor responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_krypton_cmd_queue_scheduler;
  import krypton_pkg::*;

  localparam int NQ = 4;
  localparam int QD = 4;
  localparam int QW = 2;
  localparam int AW = ADDR_WIDTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NQ-1:0]     sub_valid = '0;
  logic [NQ-1:0]     sub_ready;
  logic [NQ*AW-1:0]  sub_base = '0;
  logic [NQ*32-1:0]  sub_size = '0;
  logic [NQ-1:0]     q_enable = '0;
  logic [NQ-1:0]     q_high_prio = '0;
  logic [AW-1:0]     cp_base;
  logic [31:0]       cp_size;
  logic              cp_start;
  logic              cp_busy;
  logic              cp_done;
  logic              done_pulse;
  logic [QW-1:0]     done_qid;
  logic [NQ*16-1:0]  retired_count;
  logic [31:0]       timeout_cycles = '0;
  logic              hang_flag;
  logic              hang_clear = 1'b0;
  logic              sched_idle;

  krypton_cmd_queue_scheduler #(.NUM_QUEUES(NQ), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n),
    .sub_valid(sub_valid), .sub_ready(sub_ready),
    .sub_base(sub_base), .sub_size(sub_size),
    .q_enable(q_enable), .q_high_prio(q_high_prio),
    .cp_base(cp_base), .cp_size(cp_size), .cp_start(cp_start),
    .cp_busy(cp_busy), .cp_done(cp_done),
    .done_pulse(done_pulse), .done_qid(done_qid),
    .retired_count(retired_count),
    .timeout_cycles(timeout_cycles), .hang_flag(hang_flag),
    .hang_clear(hang_clear), .sched_idle(sched_idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending entries per queue, rr pointer, retire counts.
  logic [31:0] mq_base [NQ][$];
  logic [31:0] mq_size [NQ][$];
  int          mrr;
  logic [15:0] mret [NQ];
  int          exp_q [$];
  logic [31:0] exp_b [$];
  logic [31:0] exp_s [$];

  // Observed activity logged by the responder/monitor.
  logic [31:0] l_base [$];
  logic [31:0] l_size [$];
  int          d_qid [$];
  int          cp_lat = 2;
  bit          hold_done = 0;
  int          busy_left = 0;
  int          start_cyc = 0, done_cyc = 0, dp_cyc = 0, hang_cyc = 0;
  bit          hang_seen = 0;

  // Command processor responder and output monitor.
  initial begin
    cp_busy = 1'b0;
    cp_done = 1'b0;
    forever begin
      @(negedge clk);
      cp_done = 1'b0;
      if (!rst_n) begin
        cp_busy   = 1'b0;
        busy_left = 0;
      end else begin
        if (cp_start) begin
          l_base.push_back(cp_base);
          l_size.push_back(cp_size);
          start_cyc = cyc;
          cp_busy   = 1'b1;
          busy_left = cp_lat;
        end else if (cp_busy && !hold_done) begin
          if (busy_left == 0) begin
            cp_busy  = 1'b0;
            cp_done  = 1'b1;
            done_cyc = cyc;
          end else begin
            busy_left--;
          end
        end
        if (done_pulse) begin
          d_qid.push_back(int'(done_qid));
          dp_cyc = cyc;
        end
        if (hang_flag && !hang_seen) begin
          hang_seen = 1'b1;
          hang_cyc  = cyc;
        end
      end
    end
  end

  task automatic model_clear();
    for (int q = 0; q < NQ; q++) begin
      mq_base[q].delete();
      mq_size[q].delete();
      mret[q] = '0;
    end
    mrr = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sub_ready"}, 64'(sub_ready), 64'hF);
    check({tag, "_cp_base"}, 64'(cp_base), 64'h0);
    check({tag, "_cp_size"}, 64'(cp_size), 64'h0);
    check({tag, "_cp_start"}, 64'(cp_start), 64'h0);
    check({tag, "_done_pulse"}, 64'(done_pulse), 64'h0);
    check({tag, "_done_qid"}, 64'(done_qid), 64'h0);
    check({tag, "_retired"}, 64'(retired_count), 64'h0);
    check({tag, "_hang"}, 64'(hang_flag), 64'h0);
    check({tag, "_idle"}, 64'(sched_idle), 64'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q_enable = '0;
    repeat (2) @(negedge clk);
    model_clear();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Offer one submission for a single cycle; acceptance follows model occupancy.
  task automatic enq(input int q, input logic [31:0] base, input logic [31:0] size);
    bit exp_rdy;
    @(negedge clk);
    exp_rdy = (mq_base[q].size() < QD);
    sub_valid[q] = 1'b1;
    sub_base[q*AW +: AW] = base;
    sub_size[q*32 +: 32] = size;
    check($sformatf("sub_ready_q%0d", q), 64'(sub_ready[q]), 64'(exp_rdy));
    if (exp_rdy) begin
      mq_base[q].push_back(base);
      mq_size[q].push_back(size);
    end
    @(negedge clk);
    sub_valid = '0;
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (d_qid.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_timeout"}, 64'(d_qid.size() >= n), 64'h1);
  endtask

  // Service order from the scheduling rules over a static set of entries.
  task automatic build_expected(input logic [NQ-1:0] hi);
    logic [NQ-1:0] elig, cand;
    int g, idx;
    exp_q.delete(); exp_b.delete(); exp_s.delete();
    while (1) begin
      elig = '0;
      for (int q = 0; q < NQ; q++) elig[q] = (mq_base[q].size() != 0);
      if (elig == '0) break;
      cand = ((elig & hi) != '0) ? (elig & hi) : elig;
      g = -1;
      for (int k = 0; k < NQ; k++) begin
        idx = (mrr + k) % NQ;
        if (g < 0 && cand[idx]) g = idx;
      end
      exp_q.push_back(g);
      exp_b.push_back(mq_base[g].pop_front());
      exp_s.push_back(mq_size[g].pop_front());
      mret[g] = mret[g] + 16'd1;
      mrr = (g + 1) % NQ;
    end
  endtask

  task automatic run_batch(input logic [NQ-1:0] hi, input int lat, input string tag);
    int li;
    q_high_prio = hi;
    cp_lat = lat;
    l_base.delete(); l_size.delete(); d_qid.delete();
    build_expected(hi);
    @(negedge clk);
    q_enable = '1;
    wait_dones(exp_q.size(), 40 * (exp_q.size() + 1), tag);
    li = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < d_qid.size()) check($sformatf("%s_qid%0d", tag, i), 64'(d_qid[i]), 64'(exp_q[i]));
      if (exp_s[i] != 0) begin
        if (li < l_base.size()) begin
          check($sformatf("%s_base%0d", tag, i), 64'(l_base[li]), 64'(exp_b[i]));
          check($sformatf("%s_size%0d", tag, i), 64'(l_size[li]), 64'(exp_s[i]));
        end
        li++;
      end
    end
    check({tag, "_nstarts"}, 64'(l_base.size()), 64'(li));
    repeat (2) @(negedge clk);
    q_enable = '0;
    check({tag, "_idle"}, 64'(sched_idle), 64'h1);
    for (int q = 0; q < NQ; q++)
      check($sformatf("%s_ret%0d", tag, q), 64'(retired_count[q*16 +: 16]), 64'(mret[q]));
  endtask

  initial begin
    int k, dcount;
    logic [NQ-1:0] hi;

    model_clear();
    do_reset();

    // Single submission: launch latency, busy handshake, retirement timing.
    cp_lat = 10;
    q_enable = '1;
    l_base.delete(); l_size.delete(); d_qid.delete();
    @(negedge clk);
    sub_valid[2] = 1'b1;
    sub_base[2*AW +: AW] = 32'h1000;
    sub_size[2*32 +: 32] = 32'd3;
    @(negedge clk);
    sub_valid = '0;
    repeat (2) @(negedge clk);
    check("t1_no_early_start", 64'(cp_start), 64'h0);
    @(negedge clk);
    check("t1_start_cycle4", 64'(cp_start), 64'h1);
    check("t1_cp_base", 64'(cp_base), 64'h1000);
    check("t1_cp_size", 64'(cp_size), 64'd3);
    wait_dones(1, 60, "t1");
    if (d_qid.size() > 0) check("t1_qid", 64'(d_qid[0]), 64'd2);
    check("t1_done_lat", 64'(dp_cyc - done_cyc), 64'd2);
    check("t1_nstarts", 64'(l_base.size()), 64'd1);
    check("t1_ret2", 64'(retired_count[2*16 +: 16]), 64'd1);
    @(negedge clk);
    check("t1_idle", 64'(sched_idle), 64'h1);
    q_enable = '0;

    // Low-priority round robin over queues 0, 1, 3.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      enq(0, 32'h100 + r, 32'd1 + r);
      enq(1, 32'h200 + r, 32'd2 + r);
      enq(3, 32'h300 + r, 32'd3 + r);
    end
    run_batch(4'b0000, 1, "rr");

    // High-priority queue 1 drains before low-priority queue 0.
    do_reset();
    enq(0, 32'hA000, 32'd5);
    for (int r = 0; r < 3; r++) enq(1, 32'hB000 + 32'(r * 16), 32'd4);
    run_batch(4'b0010, 0, "prio");

    // Fill queue 0 while disabled, attempt one extra push, then drain in order.
    do_reset();
    for (int r = 0; r < QD; r++) enq(0, 32'hC000 + 32'(r), 32'd10 + 32'(r));
    check("full_ready0", 64'(sub_ready[0]), 64'h0);
    enq(0, 32'hDEAD, 32'd99);
    run_batch(4'b0000, 2, "fill");

    // Watchdog expiry, late completion, then clear.
    do_reset();
    timeout_cycles = 32'd5;
    hold_done = 1'b1;
    hang_seen = 1'b0;
    cp_lat = 0;
    l_base.delete(); l_size.delete(); d_qid.delete();
    enq(0, 32'hE000, 32'd2);
    q_enable = '1;
    k = 0;
    while (l_base.size() == 0 && k < 30) begin @(negedge clk); k++; end
    check("wd_launched", 64'(l_base.size()), 64'd1);
    k = 0;
    while (!hang_seen && k < 30) begin @(negedge clk); k++; end
    check("wd_hang_seen", 64'(hang_seen), 64'h1);
    check("wd_hang_delay", 64'(hang_cyc - start_cyc), 64'd5);
    repeat (14) @(negedge clk);
    check("wd_no_done_yet", 64'(d_qid.size()), 64'd0);
    hold_done = 1'b0;
    wait_dones(1, 20, "wd");
    if (d_qid.size() > 0) check("wd_qid", 64'(d_qid[0]), 64'd0);
    check("wd_hang_sticky", 64'(hang_flag), 64'h1);
    check("wd_ret0", 64'(retired_count[15:0]), 64'd1);
    void'(mq_base[0].pop_front());
    void'(mq_size[0].pop_front());
    mret[0] = 16'd1;
    mrr = 1;
    @(negedge clk);
    hang_clear = 1'b1;
    @(negedge clk);
    hang_clear = 1'b0;
    check("wd_hang_cleared", 64'(hang_flag), 64'h0);
    timeout_cycles = '0;
    q_enable = '0;

    // Zero-size submission then size 7 on the same queue.
    enq(3, 32'hF000, 32'd0);
    enq(3, 32'hF100, 32'd7);
    run_batch(4'b0000, 1, "zero");

    // Randomized batches, including overfill attempts and mixed priorities.
    for (int b = 0; b < 5; b++) begin
      for (int q = 0; q < NQ; q++) begin
        k = $urandom_range(0, QD + 1);
        for (int e = 0; e < k; e++)
          enq(q, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 100)));
      end
      hi = NQ'($urandom_range(0, 15));
      run_batch(hi, $urandom_range(0, 6), $sformatf("rnd%0d", b));
    end

    // Asynchronous reset while a submission is running discards everything.
    enq(1, 32'h5000, 32'd5);
    enq(2, 32'h6000, 32'd6);
    enq(2, 32'h6100, 32'd6);
    hold_done = 1'b1;
    l_base.delete(); l_size.delete(); d_qid.delete();
    q_enable = '1;
    k = 0;
    while (l_base.size() == 0 && k < 30) begin @(negedge clk); k++; end
    check("arst_launched", 64'(l_base.size()), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    dcount = d_qid.size();
    #1 check_reset_outputs("arst_async");
    @(negedge clk);
    check_reset_outputs("arst_hold");
    rst_n = 1'b1;
    model_clear();
    hold_done = 1'b0;
    repeat (20) @(negedge clk);
    check("arst_no_done", 64'(d_qid.size()), 64'(dcount));
    check("arst_no_relaunch", 64'(l_base.size()), 64'd1);
    check("arst_idle", 64'(sched_idle), 64'h1);
    check("arst_ret", 64'(retired_count), 64'h0);
    q_enable = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/krypton_cmd_queue_scheduler.md
# krypton_cmd_queue_scheduler

Multi-queue submission scheduler in front of the Krypton command processor. Host/driver submissions (command buffer base + command count) are enqueued into per-queue FIFOs. A priority-aware round-robin arbiter picks one submission at a time and launches it on the command processor's start/base/size interface. On the processor's done pulse it retires the submission, reports completion per queue, and runs a watchdog that flags a hung command buffer.

## Interface
- NUM_QUEUES, 4, number of submission queues (2..8)
- QDEPTH, 4, entries per queue FIFO (power of two, ≥2)
- QID_W, $clog2(NUM_QUEUES), queue-id width (derived)
- ADDR_WIDTH: taken from krypton_pkg
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- sub_valid  in  NUM_QUEUES  per-queue submission valid
- sub_ready  out  NUM_QUEUES  per-queue FIFO not full
- sub_base  in  NUM_QUEUES*ADDR_WIDTH  command buffer base, queue i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- sub_size  in  NUM_QUEUES*32  command count, queue i at [i*32 +: 32]
- q_enable  in  NUM_QUEUES  queue may be scheduled; enqueue is always allowed
- q_high_prio  in  NUM_QUEUES  queue belongs to the high-priority class
- cp_base  out  ADDR_WIDTH  buffer base to the command processor
- cp_size  out  32  command count to the command processor
- cp_start  out  1  launch pulse
- cp_busy  in  1  command processor not idle
- cp_done  in  1  command processor finished (1-cycle pulse)
- done_pulse  out  1  one submission retired
- done_qid  out  QID_W  queue of the retired submission, valid with done_pulse
- retired_count  out  NUM_QUEUES*16  per-queue retired-submission counters, wrap at 2^16
- timeout_cycles  in  32  watchdog limit; 0 disables the watchdog
- hang_flag  out  1  sticky watchdog expiry
- hang_clear  in  1  clears hang_flag
- sched_idle  out  1  FSM in S_IDLE and all FIFOs empty

## Operation
- Enqueue: push queue i when sub_valid[i] && sub_ready[i]. sub_ready[i] = !full[i], derived from registered occupancy only; a pop in the same cycle does not open a slot. Push and pop on the same queue in the same cycle are both performed; occupancy is unchanged.
- Eligible[i] = q_enable[i] && !empty[i]. If any eligible queue is high-priority, arbitrate only among eligible high-priority queues; otherwise arbitrate among all eligible queues. Round-robin: search from rr_ptr upward, with wrap.
- FSM:
  - S_IDLE: if any queue is eligible, register the grant qid → S_LAUNCH.
  - S_LAUNCH: pop the granted FIFO head into cp_base/cp_size registers. If size == 0 → S_RETIRE, with no launch. Otherwise → S_START.
  - S_START: hold until cp_busy == 0, then assert cp_start for one cycle → S_RUN.
  - S_RUN: on cp_done → S_RETIRE. Run the watchdog here.
  - S_RETIRE: done_pulse = 1 with done_qid = grant; increment retired_count[grant]; rr_ptr ← grant+1 mod NUM_QUEUES → S_IDLE.
- Only one submission is in flight at a time. q_enable dropping after a grant does not abort the granted submission.
- Watchdog: counter clears on entry to S_RUN and increments each S_RUN cycle. When the counter equals timeout_cycles (non-zero), set hang_flag. The FSM keeps waiting for cp_done; there is no abort. If hang_clear and a new expiry occur in the same cycle, set wins.
- cp_done outside S_RUN is ignored.
- Reset: all FIFOs empty, rr_ptr = 0, FSM in S_IDLE, watchdog counter = 0.

## Timing
- Reset values: sub_ready = all 1, cp_base = 0, cp_size = 0, cp_start = 0, done_pulse = 0, done_qid = 0, retired_count = 0, hang_flag = 0, sched_idle = 1.
- cp_start, done_pulse and the cp_base/cp_size registers are registered outputs. cp_base/cp_size are stable from S_LAUNCH exit until the next launch.
- Latency, sub_valid accepted on an empty, idle scheduler: cycle 0 push, cycle 1 S_IDLE grant, cycle 2 S_LAUNCH, cycle 3 S_START, cp_start high in cycle 4 when cp_busy == 0.
- Retirement: cp_done in cycle N produces done_pulse in cycle N+2 (S_RETIRE registered). The next grant evaluation happens in S_IDLE at N+2.
- Zero-size submission: S_LAUNCH → S_RETIRE; done_pulse 2 cycles after S_LAUNCH; cp_start is never asserted.
- Counter wrap: retired_count 0xFFFF + 1 → 0x0000, with no flag.
- Asynchronous reset mid-S_RUN discards the in-flight submission and all queued entries. No done_pulse is emitted.

## Test plan
- Single submission on queue 2 (base 0x1000, size 3); model cp_busy for 10 cycles and then pulse cp_done → exactly one cp_start with cp_base 0x1000 and cp_size 3; done_pulse with done_qid 2; retired_count[2] = 1; sched_idle returns to 1.
- Queues 0, 1 and 3 each hold 2 entries, all low priority → launch order 0,1,3,0,1,3.
- Queue 1 high-priority with 3 entries, queue 0 low-priority with 1 entry, all enqueued before the first grant → queue 1 is served ×3, then queue 0.
- Fill queue 0 to QDEPTH with q_enable[0] = 0 → sub_ready[0] = 0 and the extra sub_valid is not accepted. Raise q_enable[0] → 4 launches in FIFO order.
- timeout_cycles = 5 and cp_done withheld for 20 cycles → hang_flag rises after 5 S_RUN cycles; the later cp_done still retires the submission. hang_clear then drops hang_flag to 0.
- Zero-size submission followed by size 7 on the same queue → the first retires with no cp_start; the second launches with cp_size 7. Assert rst_n low mid-S_RUN → all outputs return to their reset values and no done_pulse is emitted.
